// File: rtl/pcie_rx_avst2axis.sv
// -----------------------------------------------------------------------------
// pcie_rx_avst2axis
//
// Receive-direction bridge from the PCIe HIP two-channel AVST RX interface to a
// single AXI4-Stream RX beat that carries both TLP channels side by side.
//
// - HIP beats are buffered in a FIFO that is deep enough to absorb the HIP
//   ready latency. Beats are written whenever any channel is valid, even when
//   avl_rx_ready is low.
// - A framing checker walks channel 0 then channel 1 of every stored beat and
//   raises a sticky error on SOP/EOP sequence violations. It never drops data.
// - Optional completion-credit reporting sums the CplD dwords of each popped
//   beat. Define PCIE_RX_CPL_CREDIT_EN to enable it. When it is not defined,
//   rx_cpl_valid and rx_cpl_dw are tied to 0.
//
// Ports
//   avl_clk, avl_rst          clock, synchronous active-high reset
//   avl_rx_valid/sop/eop      per-channel HIP flags (2 bits each)
//   avl_rx_hdr, avl_rx_data   channel i at [i*W +: W]
//   avl_rx_ready              registered backpressure to the HIP
//   axis_rx_tvalid/tready     downstream handshake
//   axis_rx_ch_valid/sop/eop  per-channel flags of the head beat
//   axis_rx_hdr/payload       head beat header and payload
//   rx_cpl_valid, rx_cpl_dw   one-cycle pulse with the CplD dwords released
//   rx_overflow_err           sticky: a beat arrived while the FIFO was full
//   rx_framing_err            sticky: SOP/EOP sequence violation
// -----------------------------------------------------------------------------
module pcie_rx_avst2axis #(
  parameter int DATA_W        = 256,
  parameter int HDR_W         = 128,
  parameter int FIFO_DEPTH    = 16,
  parameter int READY_LATENCY = 3
) (
  input  logic                avl_clk,
  input  logic                avl_rst,
  input  logic [1:0]          avl_rx_valid,
  input  logic [1:0]          avl_rx_sop,
  input  logic [1:0]          avl_rx_eop,
  input  logic [2*HDR_W-1:0]  avl_rx_hdr,
  input  logic [2*DATA_W-1:0] avl_rx_data,
  output logic                avl_rx_ready,
  output logic                axis_rx_tvalid,
  input  logic                axis_rx_tready,
  output logic [1:0]          axis_rx_ch_valid,
  output logic [1:0]          axis_rx_sop,
  output logic [1:0]          axis_rx_eop,
  output logic [2*HDR_W-1:0]  axis_rx_hdr,
  output logic [2*DATA_W-1:0] axis_rx_payload,
  output logic                rx_cpl_valid,
  output logic [11:0]         rx_cpl_dw,
  output logic                rx_overflow_err,
  output logic                rx_framing_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 6 + 2*HDR_W + 2*DATA_W;
  localparam logic [AW:0] DEPTH_C      = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] READY_MARGIN = (AW+1)'(READY_LATENCY + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  // One framing step for a single channel: returns {err, next_state}.
  function automatic logic [1:0] frame_step(input logic [0:0] st, input logic v,
                                            input logic sop, input logic eop);
    logic       err;
    logic [0:0] nxt;
    err = 1'b0;
    nxt = st;
    if (v) begin
      case (st)
        ST_IDLE: begin
          if (sop) begin
            nxt = eop ? ST_IDLE : ST_IN_PKT;
          end else begin
            err = 1'b1;
            nxt = ST_IDLE;
          end
        end
        ST_IN_PKT: begin
          if (sop) begin
            // A new SOP inside a packet restarts the packet.
            err = 1'b1;
            nxt = eop ? ST_IDLE : ST_IN_PKT;
          end else if (eop) begin
            nxt = ST_IDLE;
          end else begin
            nxt = ST_IN_PKT;
          end
        end
        default: begin
          err = 1'b1;
          nxt = ST_IDLE;
        end
      endcase
    end else begin
      nxt = st;
    end
    return {err, nxt[0]};
  endfunction

  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   free_d;
  logic          ready_q, ready_d;
  logic          ovf_q, ovf_d;
  logic          frm_q, frm_d;
  logic [0:0]    state_q, state_d;
  logic [1:0]    step0, step1;
  logic          push_req, push_acc, pop, full;
  logic [EW-1:0] wr_entry, head_entry, head_gated;

  assign wr_entry   = {avl_rx_valid, avl_rx_sop, avl_rx_eop, avl_rx_hdr, avl_rx_data};
  assign head_entry = fifo_mem_q[rd_ptr_q];

  // Output fields read zero whenever the FIFO is empty, including in reset.
  assign axis_rx_tvalid   = (count_q != {(AW+1){1'b0}});
  assign head_gated       = axis_rx_tvalid ? head_entry : {EW{1'b0}};
  assign axis_rx_ch_valid = head_gated[EW-1 -: 2];
  assign axis_rx_sop      = head_gated[EW-3 -: 2];
  assign axis_rx_eop      = head_gated[EW-5 -: 2];
  assign axis_rx_hdr      = head_gated[2*DATA_W +: 2*HDR_W];
  assign axis_rx_payload  = head_gated[0 +: 2*DATA_W];

  assign avl_rx_ready    = ready_q;
  assign rx_overflow_err = ovf_q;
  assign rx_framing_err  = frm_q;

  // FIFO control: pop is applied before push, so a full FIFO accepts a beat
  // in the same cycle that it releases one.
  always_comb begin
    push_req = |avl_rx_valid;
    full     = (count_q == DEPTH_C);
    pop      = axis_rx_tvalid && axis_rx_tready;
    push_acc = push_req && (!full || pop);
    wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_acc, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    free_d  = DEPTH_C - count_d;
    ready_d = (free_d > READY_MARGIN);
    ovf_d   = ovf_q | (push_req & full & ~pop);
  end

  // Framing checker: channel 0 then channel 1 of each accepted beat.
  always_comb begin
    step0 = frame_step(state_q, avl_rx_valid[0], avl_rx_sop[0], avl_rx_eop[0]);
    step1 = frame_step(step0[0], avl_rx_valid[1], avl_rx_sop[1], avl_rx_eop[1]);
    if (push_acc) begin
      state_d = step1[0];
      frm_d   = frm_q | step0[1] | step1[1];
    end else begin
      state_d = state_q;
      frm_d   = frm_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge avl_clk) begin
    if (avl_rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      frm_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      frm_q    <= frm_d;
      state_q  <= state_d;
    end
  end

  // FIFO storage; contents need no reset because the outputs are gated.
  always_ff @(posedge avl_clk) begin
    if (push_acc && !avl_rst) begin
      fifo_mem_q[wr_ptr_q] <= wr_entry;
    end
  end

`ifdef PCIE_RX_CPL_CREDIT_EN
  // Dwords carried by one channel if it starts a CplD (length 0 means 1024).
  function automatic logic [11:0] cpl_dwords(input logic v, input logic sop,
                                             input logic [7:0] fmt_type,
                                             input logic [9:0] len);
    logic [11:0] dw;
    if (v && sop && (fmt_type[7:5] == 3'b010) && (fmt_type[4:0] == 5'b01010)) begin
      dw = (len == 10'd0) ? 12'd1024 : {2'b00, len};
    end else begin
      dw = 12'd0;
    end
    return dw;
  endfunction

  logic [11:0] cpl_sum_s;
  logic [11:0] cpl_dw_q, cpl_dw_d;
  logic        cpl_valid_q, cpl_valid_d;

  // Sum the CplD dwords of both channels of the beat being popped.
  always_comb begin
    cpl_sum_s = cpl_dwords(axis_rx_ch_valid[0], axis_rx_sop[0],
                           axis_rx_hdr[24 +: 8], axis_rx_hdr[0 +: 10])
              + cpl_dwords(axis_rx_ch_valid[1], axis_rx_sop[1],
                           axis_rx_hdr[HDR_W+24 +: 8], axis_rx_hdr[HDR_W +: 10]);
    if (pop && (cpl_sum_s != 12'd0)) begin
      cpl_valid_d = 1'b1;
      cpl_dw_d    = cpl_sum_s;
    end else begin
      cpl_valid_d = 1'b0;
      cpl_dw_d    = 12'd0;
    end
  end

  // Credit report register: a single-cycle pulse after each CplD pop.
  always_ff @(posedge avl_clk) begin
    if (avl_rst) begin
      cpl_valid_q <= 1'b0;
      cpl_dw_q    <= 12'd0;
    end else begin
      cpl_valid_q <= cpl_valid_d;
      cpl_dw_q    <= cpl_dw_d;
    end
  end

  assign rx_cpl_valid = cpl_valid_q;
  assign rx_cpl_dw    = cpl_dw_q;
`else
  assign rx_cpl_valid = 1'b0;
  assign rx_cpl_dw    = 12'd0;
`endif

endmodule

// File: tb/tb_pcie_rx_avst2axis.sv
// Scoreboard bench for pcie_rx_avst2axis: stimulus pushes expected beats into
// a queue, a monitor pops and compares on every AXI-S handshake and checks the
// completion-credit pulse one cycle after each pop.
module tb_pcie_rx_avst2axis;
  localparam int DATA_W = 256;
  localparam int HDR_W  = 128;

  typedef struct packed {
    logic [1:0]          v;
    logic [1:0]          sop;
    logic [1:0]          eop;
    logic [2*HDR_W-1:0]  hdr;
    logic [2*DATA_W-1:0] data;
    logic [11:0]         cpl;
  } beat_t;

  logic                avl_clk = 1'b0;
  logic                avl_rst;
  logic [1:0]          avl_rx_valid, avl_rx_sop, avl_rx_eop;
  logic [2*HDR_W-1:0]  avl_rx_hdr;
  logic [2*DATA_W-1:0] avl_rx_data;
  logic                avl_rx_ready;
  logic                axis_rx_tvalid, axis_rx_tready;
  logic [1:0]          axis_rx_ch_valid, axis_rx_sop, axis_rx_eop;
  logic [2*HDR_W-1:0]  axis_rx_hdr;
  logic [2*DATA_W-1:0] axis_rx_payload;
  logic                rx_cpl_valid;
  logic [11:0]         rx_cpl_dw;
  logic                rx_overflow_err, rx_framing_err;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb_q[$];

  pcie_rx_avst2axis #(.DATA_W(DATA_W), .HDR_W(HDR_W), .FIFO_DEPTH(16), .READY_LATENCY(3)) dut (
    .avl_clk(avl_clk), .avl_rst(avl_rst),
    .avl_rx_valid(avl_rx_valid), .avl_rx_sop(avl_rx_sop), .avl_rx_eop(avl_rx_eop),
    .avl_rx_hdr(avl_rx_hdr), .avl_rx_data(avl_rx_data), .avl_rx_ready(avl_rx_ready),
    .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tready(axis_rx_tready),
    .axis_rx_ch_valid(axis_rx_ch_valid), .axis_rx_sop(axis_rx_sop), .axis_rx_eop(axis_rx_eop),
    .axis_rx_hdr(axis_rx_hdr), .axis_rx_payload(axis_rx_payload),
    .rx_cpl_valid(rx_cpl_valid), .rx_cpl_dw(rx_cpl_dw),
    .rx_overflow_err(rx_overflow_err), .rx_framing_err(rx_framing_err)
  );

  always #5 avl_clk = ~avl_clk;

  task automatic tick();
    @(posedge avl_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Build a beat: random payload and header, with fmt/type and length forced.
  function automatic beat_t mk(input logic [1:0] v, input logic [1:0] sop, input logic [1:0] eop,
                               input logic [7:0] ft0, input logic [9:0] len0,
                               input logic [7:0] ft1, input logic [9:0] len1,
                               input logic [11:0] cpl);
    beat_t b;
    b.v = v; b.sop = sop; b.eop = eop;
    for (int k = 0; k < 2*HDR_W/32; k++)  b.hdr[k*32 +: 32]  = $urandom();
    for (int k = 0; k < 2*DATA_W/32; k++) b.data[k*32 +: 32] = $urandom();
    b.hdr[24 +: 8]        = ft0;
    b.hdr[0 +: 10]        = len0;
    b.hdr[HDR_W+24 +: 8]  = ft1;
    b.hdr[HDR_W +: 10]    = len1;
`ifdef PCIE_RX_CPL_CREDIT_EN
    b.cpl = cpl;
`else
    b.cpl = 12'd0 & cpl;
`endif
    return b;
  endfunction

  function automatic beat_t single2();
    return mk(2'b11, 2'b11, 2'b11, 8'h00, 10'd4, 8'h00, 10'd8, 12'd0);
  endfunction

  task automatic drive(input beat_t b, input bit keep);
    avl_rx_valid = b.v;
    avl_rx_sop   = b.sop;
    avl_rx_eop   = b.eop;
    avl_rx_hdr   = b.hdr;
    avl_rx_data  = b.data;
    if (keep) sb_q.push_back(b);
    tick();
    avl_rx_valid = 2'b00;
    avl_rx_sop   = 2'b00;
    avl_rx_eop   = 2'b00;
  endtask

  task automatic wait_empty(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (sb_q.size() == 0 && !axis_rx_tvalid) break;
      tick();
    end
    if (i == bound) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", sb_q.size());
    end
    tick();
    tick();
  endtask

  // Monitor: compare popped beats and the credit pulse that follows each pop.
  initial begin
    beat_t e;
    logic [11:0] exp_cpl_next;
    exp_cpl_next = 12'd0;
    forever begin
      @(negedge avl_clk);
      if (avl_rst) begin
        exp_cpl_next = 12'd0;
      end else begin
        n_vec++;
        if ({rx_cpl_valid, rx_cpl_dw} !== {(exp_cpl_next != 12'd0), exp_cpl_next}) begin
          n_err++;
          $display("FAIL cpl_pulse: got valid=%0b dw=%0d expected valid=%0b dw=%0d",
                   rx_cpl_valid, rx_cpl_dw, (exp_cpl_next != 12'd0), exp_cpl_next);
        end
        if (axis_rx_tvalid && axis_rx_tready) begin
          n_vec++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: got flags=%h expected no beat",
                     {axis_rx_ch_valid, axis_rx_sop, axis_rx_eop});
            exp_cpl_next = 12'd0;
          end else begin
            e = sb_q.pop_front();
            if ({axis_rx_ch_valid, axis_rx_sop, axis_rx_eop, axis_rx_hdr, axis_rx_payload}
                !== {e.v, e.sop, e.eop, e.hdr, e.data}) begin
              n_err++;
              $display("FAIL beat_data: got flags=%h hdr=%h data=%h expected flags=%h hdr=%h data=%h",
                       {axis_rx_ch_valid, axis_rx_sop, axis_rx_eop}, axis_rx_hdr[63:0],
                       axis_rx_payload[63:0], {e.v, e.sop, e.eop}, e.hdr[63:0], e.data[63:0]);
            end
            exp_cpl_next = e.cpl;
          end
        end else begin
          exp_cpl_next = 12'd0;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t b;
    int sent;
    avl_rst = 1'b1;
    avl_rx_valid = 2'b00; avl_rx_sop = 2'b00; avl_rx_eop = 2'b00;
    avl_rx_hdr = '0; avl_rx_data = '0;
    axis_rx_tready = 1'b0;
    repeat (3) tick();

    // Reset state.
    chk("rst_tvalid", {63'd0, axis_rx_tvalid}, 64'd0);
    chk("rst_ready", {63'd0, avl_rx_ready}, 64'd0);
    chk("rst_fields", {58'd0, axis_rx_ch_valid, axis_rx_sop, axis_rx_eop}, 64'd0);
    chk("rst_hdr_data", {62'd0, |axis_rx_hdr, |axis_rx_payload}, 64'd0);
    chk("rst_cpl", {51'd0, rx_cpl_valid, rx_cpl_dw}, 64'd0);
    chk("rst_errs", {62'd0, rx_overflow_err, rx_framing_err}, 64'd0);
    avl_rst = 1'b0;
    tick();
    chk("ready_after_rst", {63'd0, avl_rx_ready}, 64'd1);

    // Streaming: each beat is the head one cycle after it is written.
    axis_rx_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b = single2();
      drive(b, 1'b1);
      chk("stream_lat", axis_rx_payload[63:0], b.data[63:0]);
    end
    wait_empty(50);
    chk("stream_errs", {62'd0, rx_overflow_err, rx_framing_err}, 64'd0);

    // CplD credit: 0x010 + 0x000(=1024) = 1040; MRd, Cpl and invalid channels give 0.
    drive(mk(2'b11, 2'b11, 2'b11, 8'h4A, 10'h010, 8'h4A, 10'h000, 12'd1040), 1'b1);
    drive(mk(2'b11, 2'b11, 2'b11, 8'h00, 10'h010, 8'h00, 10'h005, 12'd0), 1'b1);
    drive(mk(2'b11, 2'b11, 2'b11, 8'h0A, 10'h001, 8'h4A, 10'h003, 12'd3), 1'b1);
    drive(mk(2'b10, 2'b10, 2'b10, 8'h4A, 10'h007, 8'h4A, 10'h3FF, 12'd1023), 1'b1);
    tick();
    drive(mk(2'b11, 2'b11, 2'b11, 8'h4A, 10'h000, 8'h4A, 10'h000, 12'd2048), 1'b1);
    wait_empty(20);
    chk("cpl_errs", {62'd0, rx_overflow_err, rx_framing_err}, 64'd0);

    // Framing: valid without sop in IDLE, then sop, then sop again.
    drive(mk(2'b01, 2'b00, 2'b00, 8'h00, 10'd1, 8'h00, 10'd1, 12'd0), 1'b1);
    drive(mk(2'b01, 2'b01, 2'b00, 8'h00, 10'd2, 8'h00, 10'd2, 12'd0), 1'b1);
    drive(mk(2'b01, 2'b01, 2'b01, 8'h00, 10'd3, 8'h00, 10'd3, 12'd0), 1'b1);
    wait_empty(20);
    chk("framing_err", {63'd0, rx_framing_err}, 64'd1);
    chk("framing_no_ovf", {63'd0, rx_overflow_err}, 64'd0);

    // Backpressure honouring the ready latency.
    axis_rx_tready = 1'b0;
    sent = 0;
    for (int i = 0; i < 20 && avl_rx_ready; i++) begin
      drive(single2(), 1'b1);
      sent++;
    end
    chk("bp_sent_before_drop", sent, 12);
    chk("bp_ready_low", {63'd0, avl_rx_ready}, 64'd0);
    for (int i = 0; i < 3; i++) drive(single2(), 1'b1);
    chk("bp_no_ovf", {63'd0, rx_overflow_err}, 64'd0);
    drive(single2(), 1'b1);
    // FIFO is now full: a push with a simultaneous pop is accepted.
    axis_rx_tready = 1'b1;
    drive(single2(), 1'b1);
    chk("full_push_pop_no_ovf", {63'd0, rx_overflow_err}, 64'd0);
    wait_empty(40);
    chk("bp_ready_back", {63'd0, avl_rx_ready}, 64'd1);

    // Overflow: 17 writes into a stalled FIFO, the 17th is dropped.
    axis_rx_tready = 1'b0;
    for (int i = 0; i < 16; i++) drive(single2(), 1'b1);
    chk("ovf_before", {63'd0, rx_overflow_err}, 64'd0);
    drive(single2(), 1'b0);
    chk("ovf_set", {63'd0, rx_overflow_err}, 64'd1);
    axis_rx_tready = 1'b1;
    wait_empty(40);
    chk("ovf_sticky", {63'd0, rx_overflow_err}, 64'd1);

    // Reset mid-packet with 5 beats held.
    axis_rx_tready = 1'b0;
    for (int i = 0; i < 4; i++) drive(single2(), 1'b1);
    drive(mk(2'b01, 2'b01, 2'b00, 8'h00, 10'd9, 8'h00, 10'd9, 12'd0), 1'b1);
    chk("mid_tvalid", {63'd0, axis_rx_tvalid}, 64'd1);
    avl_rst = 1'b1;
    sb_q.delete();
    tick();
    chk("mid_rst_tvalid", {63'd0, axis_rx_tvalid}, 64'd0);
    chk("mid_rst_ready", {63'd0, avl_rx_ready}, 64'd0);
    chk("mid_rst_flags", {62'd0, rx_overflow_err, rx_framing_err}, 64'd0);
    avl_rst = 1'b0;
    tick();
    chk("mid_rel_ready", {63'd0, avl_rx_ready}, 64'd1);
    chk("mid_rel_tvalid", {63'd0, axis_rx_tvalid}, 64'd0);
    axis_rx_tready = 1'b1;
    drive(mk(2'b01, 2'b01, 2'b01, 8'h4A, 10'h020, 8'h00, 10'd0, 12'd32), 1'b1);
    wait_empty(20);
    chk("post_rst_framing", {63'd0, rx_framing_err}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
